pwm_capture: RTL

//  APB peripheral that measures the high time and period of an external PWM waveform.

---
 rtl/pwm_capture.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: APB peripheral that measures the high time and period of an
// external PWM waveform, in pclk cycles.
//
// Ports:
//   pclk, presetn          clock (rising edge), asynchronous active-low reset
//   psel, penable, paddr,  APB slave, zero wait-state; prdata/pslverr are
//   pwrite, pstrb, pwdata  registered during the setup phase
//   prdata, pready, pslverr
//   pwm_in                 asynchronous PWM input
//   irq                    measurement interrupt (only with PWM_CAPTURE_IRQ_EN)
//
// Register map: 0x00 CTRL {irq_en, en}, 0x04 STATUS W1C {ovf, valid},
//               0x08 HIGH, 0x0C PERIOD. Other addresses return pslverr.
//
// Optional feature macro: PWM_CAPTURE_IRQ_EN adds the irq output and makes
// CTRL[1] writable.
//
// State | meaning
// IDLE  | capture disabled, counter cleared
// ARM   | waiting for a rising edge to start a measurement
// HIGH  | counting the high phase
// LOW   | counting the low phase; next rise completes the period

module pwm_capture #(
    parameter int RESOLUTION  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [3:0]  pstrb,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [RESOLUTION-1:0] CNT_MAX = '1;
    localparam logic [RESOLUTION-1:0] CNT_ONE = RESOLUTION'(1);

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
    localparam logic [31:0] ADDR_HIGH   = 32'h0000_0008;
    localparam logic [31:0] ADDR_PERIOD = 32'h0000_000C;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    state_t                  state, state_nx;
    logic [RESOLUTION-1:0]   cnt, cnt_nx;
    logic [RESOLUTION-1:0]   hi_cap, hi_cap_nx;
    logic [RESOLUTION-1:0]   high_r, period_r;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    pwm_d;
    logic                    pwm_s, rise, fall;
    logic                    res_load, ovf_set;
    logic                    en, valid, ovf, irq_en_rd;
    logic                    apb_setup, apb_wr, wr_ctrl, wr_stat, addr_ok;
    logic [31:0]             rdata;
    logic                    unused_apb;

    // Input synchronizer plus one flop for edge detection.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_d  <= pwm_s;
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_d;
    assign fall  = ~pwm_s & pwm_d;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_cap <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            hi_cap <= hi_cap_nx;
        end
    end

    // HIGH checks saturation before the fall: a high phase of CNT_MAX cycles
    // can never give a representable period, so it is an overflow. In LOW the
    // rise wins, so a period of exactly CNT_MAX is still a valid result.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_cap_nx = hi_cap;
        res_load  = 1'b0;
        ovf_set   = 1'b0;
        if (!en) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE: state_nx = S_ARM;
                S_ARM: begin
                    if (rise) begin
                        state_nx = S_HIGH;
                        cnt_nx   = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (cnt == CNT_MAX) begin
                        ovf_set  = 1'b1;
                        state_nx = S_ARM;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                        if (fall) begin
                            hi_cap_nx = cnt;
                            state_nx  = S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        res_load = 1'b1;
                        state_nx = S_HIGH;
                        cnt_nx   = CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        ovf_set  = 1'b1;
                        state_nx = S_ARM;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    assign apb_setup = psel & ~penable;
    assign apb_wr    = psel & penable & pwrite;
    assign wr_ctrl   = apb_wr && (paddr == ADDR_CTRL);
    assign wr_stat   = apb_wr && (paddr == ADDR_STATUS);

    always_comb begin
        rdata   = '0;
        addr_ok = 1'b1;
        case (paddr)
            ADDR_CTRL:   rdata = {30'b0, irq_en_rd, en};
            ADDR_STATUS: rdata = {30'b0, ovf, valid};
            ADDR_HIGH:   rdata = 32'(high_r);
            ADDR_PERIOD: rdata = 32'(period_r);
            default:     addr_ok = 1'b0;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prdata  <= '0;
            pslverr <= 1'b0;
            pready  <= 1'b0;
        end else begin
            pready <= 1'b1;
            if (apb_setup) begin
                pslverr <= ~addr_ok;
                prdata  <= (pwrite || !addr_ok) ? 32'b0 : rdata;
            end
        end
    end

    // Hardware set has priority over a simultaneous write-one-to-clear.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            en       <= 1'b0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            high_r   <= '0;
            period_r <= '0;
        end else begin
            if (wr_ctrl) en <= pwdata[0];
            valid <= res_load | (valid & ~(wr_stat & pwdata[0]));
            ovf   <= ovf_set  | (ovf   & ~(wr_stat & pwdata[1]));
            if (res_load) begin
                high_r   <= hi_cap;
                period_r <= cnt;
            end
        end
    end

`ifdef PWM_CAPTURE_IRQ_EN
    logic irq_en;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= pwdata[1];
            irq <= irq_en & (valid | ovf);
        end
    end

    assign irq_en_rd  = irq_en;
    assign unused_apb = ^{pstrb, pwdata[31:2]};
`else
    assign irq_en_rd  = 1'b0;
    assign unused_apb = ^{pstrb, pwdata[31:1]};
`endif

endmodule
